ctrl_gen: RTL and testbench

Parametrised successor to the SISC multi-cycle control FSM, with the full fetch/decode/execute/mem/writeback sequence implemented.
- Decodes the instruction-register opcode and mode fields.
- Drives all datapath enables: PC, IR, register file, ALU, data memory and status register.
- Evaluates branch conditions against the status flags.
- Has a sticky HALT state in place of a simulator stop.
- Optional short-cycle mode skips MEM for instructions that do not access memory.

---
 rtl/sisc_pkg.sv | 35 +++
 rtl/ctrl_gen_br_eval.sv | 42 ++++
 rtl/ctrl_gen.sv | 154 +++++++++++++++
 tb/tb_ctrl_gen.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// Shared constants for the SISC multi-cycle control path: state codes,
// opcode values, the immediate addressing mode and ALU operation selects.
package sisc_pkg;

  // Control FSM state encodings (3 bits).
  localparam logic [2:0] ST_START0    = 3'd0;
  localparam logic [2:0] ST_START1    = 3'd1;
  localparam logic [2:0] ST_FETCH     = 3'd2;
  localparam logic [2:0] ST_DECODE    = 3'd3;
  localparam logic [2:0] ST_EXECUTE   = 3'd4;
  localparam logic [2:0] ST_MEM       = 3'd5;
  localparam logic [2:0] ST_WRITEBACK = 3'd6;
  localparam logic [2:0] ST_HALT      = 3'd7;

  // Opcode values; unlisted codes behave as NOOP.
  localparam int OP_NOOP = 0;
  localparam int OP_LOD  = 1;
  localparam int OP_STR  = 2;
  localparam int OP_SWP  = 3;
  localparam int OP_BRA  = 4;
  localparam int OP_BRR  = 5;
  localparam int OP_BNE  = 6;
  localparam int OP_BNR  = 7;
  localparam int OP_ALU  = 8;
  localparam int OP_HLT  = 15;

  // mm value that selects the immediate operand for ALU instructions.
  localparam int AM_IMM = 8;

  // alu_op encodings: {addr_calc, imm_sel}.
  localparam logic [1:0] ALU_RR   = 2'b00;
  localparam logic [1:0] ALU_RI   = 2'b01;
  localparam logic [1:0] ALU_ADDR = 2'b11;

endpackage

// File: rtl/ctrl_gen_br_eval.sv
// Branch condition evaluator: decides whether a branch opcode is taken
// against the status flags and whether its target is absolute.
// Purely combinational so a pipelined core can reuse it in any stage.
module br_eval #(
  parameter int OPW   = 4,
  parameter int MMW   = 4,
  parameter int STATW = 4
) (
  input  logic [OPW-1:0]   opcode,
  input  logic [MMW-1:0]   mm,
  input  logic [STATW-1:0] stat,
  output logic             taken,
  output logic             absolute
);
  import sisc_pkg::*;

  logic [MMW-1:0] w_hit;
  logic           w_is_bra;
  logic           w_is_brr;
  logic           w_is_bne;
  logic           w_is_bnr;

  // Flags selected by the mask; STATW equals MMW by construction.
  assign w_hit    = MMW'(stat) & mm;
  assign w_is_bra = (opcode == OPW'(OP_BRA));
  assign w_is_brr = (opcode == OPW'(OP_BRR));
  assign w_is_bne = (opcode == OPW'(OP_BNE));
  assign w_is_bnr = (opcode == OPW'(OP_BNR));

  // Branch-if-set family treats an empty mask as unconditional;
  // branch-if-clear family is taken when no masked flag is set.
  always_comb begin
    taken    = 1'b0;
    absolute = w_is_bra | w_is_bne;
    if (w_is_bra || w_is_brr) begin
      taken = (mm == '0) || (w_hit != '0);
    end else if (w_is_bne || w_is_bnr) begin
      taken = (w_hit == '0);
    end
  end

endmodule

// File: rtl/ctrl_gen.sv
// SISC multi-cycle control FSM: START0/START1 reset sequence, then
// FETCH, DECODE, EXECUTE, MEM, WRITEBACK per instruction, with a sticky
// HALT. Outputs are Moore-style decodes of the state and live IR fields.
module ctrl_gen #(
  parameter int OPW         = 4,
  parameter int MMW         = 4,
  parameter int STATW       = 4,
  parameter int AM_IMM      = sisc_pkg::AM_IMM,
  parameter bit SHORT_CYCLE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPW-1:0]   opcode,
  input  logic [MMW-1:0]   mm,
  input  logic [STATW-1:0] stat,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             br_sel,
  output logic             pc_rst,
  output logic             ir_load,
  output logic             rf_we,
  output logic             wb_sel,
  output logic [1:0]       alu_op,
  output logic             stat_en,
  output logic             dm_we,
  output logic             mm_sel,
  output logic             halted,
  output logic [2:0]       dbg_state
);
  import sisc_pkg::*;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_taken;
  logic       w_abs;
  logic       w_is_lod;
  logic       w_is_str;
  logic       w_is_swp;
  logic       w_is_alu;
  logic       w_is_hlt;
  logic       w_mem_op;

  assign w_is_lod = (opcode == OPW'(OP_LOD));
  assign w_is_str = (opcode == OPW'(OP_STR));
  assign w_is_swp = (opcode == OPW'(OP_SWP));
  assign w_is_alu = (opcode == OPW'(OP_ALU));
  assign w_is_hlt = (opcode == OPW'(OP_HLT));
  // Instructions that must pass through MEM even in short-cycle mode.
  assign w_mem_op = w_is_lod | w_is_str | w_is_swp;

  br_eval #(
    .OPW  (OPW),
    .MMW  (MMW),
    .STATW(STATW)
  ) u_br_eval (
    .opcode  (opcode),
    .mm      (mm),
    .stat    (stat),
    .taken   (w_taken),
    .absolute(w_abs)
  );

  // State register; reset lands in START0 immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_START0;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state sequencing; HALT only leaves through reset.
  always_comb begin
    w_next = ST_START0;
    case (r_state)
      ST_START0:    w_next = ST_START1;
      ST_START1:    w_next = ST_FETCH;
      ST_FETCH:     w_next = ST_DECODE;
      ST_DECODE:    w_next = w_is_hlt ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE:   w_next = (SHORT_CYCLE && !w_mem_op) ? ST_WRITEBACK : ST_MEM;
      ST_MEM:       w_next = ST_WRITEBACK;
      ST_WRITEBACK: w_next = ST_FETCH;
      ST_HALT:      w_next = ST_HALT;
      default:      w_next = ST_START0;
    endcase
  end

  // Datapath control decode; rst masks every enable combinationally so a
  // write in flight drops in the same cycle reset is raised.
  always_comb begin
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    pc_rst   = rst;
    ir_load  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    alu_op   = ALU_RR;
    stat_en  = 1'b0;
    dm_we    = 1'b0;
    mm_sel   = 1'b0;
    halted   = 1'b0;
    if (!rst) begin
      case (r_state)
        ST_START1: begin
          pc_rst = 1'b1;
        end
        ST_FETCH: begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
        end
        ST_DECODE: begin
          if (w_taken) begin
            pc_write = 1'b1;
            pc_sel   = 1'b1;
            br_sel   = w_abs;
          end
        end
        ST_EXECUTE: begin
          if (w_is_alu) begin
            alu_op  = (mm == MMW'(AM_IMM)) ? ALU_RI : ALU_RR;
            stat_en = 1'b1;
          end else if (w_is_lod || w_is_str) begin
            alu_op = ALU_ADDR;
          end
        end
        ST_MEM: begin
          if (w_is_str) begin
            dm_we  = 1'b1;
            mm_sel = 1'b1;
          end else if (w_is_lod) begin
            mm_sel = 1'b1;
          end
        end
        ST_WRITEBACK: begin
          if (w_is_alu || w_is_swp) begin
            rf_we = 1'b1;
          end else if (w_is_lod) begin
            rf_we  = 1'b1;
            wb_sel = 1'b1;
            mm_sel = 1'b1;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = r_state;

endmodule

// File: tb/tb_ctrl_gen.sv
// Bench for ctrl_gen: one instance in normal mode (a) and one in
// short-cycle mode (b), each checked cycle by cycle against a per-
// instruction list of expected states and control vectors.
module tb_ctrl_gen;
  import sisc_pkg::*;

  // Control vector bit positions.
  localparam int B_PCW   = 12;
  localparam int B_PCSEL = 11;
  localparam int B_BRSEL = 10;
  localparam int B_PCRST = 9;
  localparam int B_IRL   = 8;
  localparam int B_RFWE  = 7;
  localparam int B_WBSEL = 6;
  localparam int B_ALU1  = 5;
  localparam int B_ALU0  = 4;
  localparam int B_STEN  = 3;
  localparam int B_DMWE  = 2;
  localparam int B_MMSEL = 1;
  localparam int B_HALT  = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] opcode_a, mm_a, stat_a;
  logic [3:0] opcode_b, mm_b, stat_b;

  logic pc_write_a, pc_sel_a, br_sel_a, pc_rst_a, ir_load_a, rf_we_a, wb_sel_a;
  logic stat_en_a, dm_we_a, mm_sel_a, halted_a;
  logic [1:0] alu_op_a;
  logic [2:0] state_a;
  logic pc_write_b, pc_sel_b, br_sel_b, pc_rst_b, ir_load_b, rf_we_b, wb_sel_b;
  logic stat_en_b, dm_we_b, mm_sel_b, halted_b;
  logic [1:0] alu_op_b;
  logic [2:0] state_b;

  ctrl_gen #(.SHORT_CYCLE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode_a), .mm(mm_a), .stat(stat_a),
    .pc_write(pc_write_a), .pc_sel(pc_sel_a), .br_sel(br_sel_a), .pc_rst(pc_rst_a),
    .ir_load(ir_load_a), .rf_we(rf_we_a), .wb_sel(wb_sel_a), .alu_op(alu_op_a),
    .stat_en(stat_en_a), .dm_we(dm_we_a), .mm_sel(mm_sel_a), .halted(halted_a),
    .dbg_state(state_a)
  );

  ctrl_gen #(.SHORT_CYCLE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode_b), .mm(mm_b), .stat(stat_b),
    .pc_write(pc_write_b), .pc_sel(pc_sel_b), .br_sel(br_sel_b), .pc_rst(pc_rst_b),
    .ir_load(ir_load_b), .rf_we(rf_we_b), .wb_sel(wb_sel_b), .alu_op(alu_op_b),
    .stat_en(stat_en_b), .dm_we(dm_we_b), .mm_sel(mm_sel_b), .halted(halted_b),
    .dbg_state(state_b)
  );

  logic [12:0] out_a, out_b;
  assign out_a = {pc_write_a, pc_sel_a, br_sel_a, pc_rst_a, ir_load_a, rf_we_a,
                  wb_sel_a, alu_op_a, stat_en_a, dm_we_a, mm_sel_a, halted_a};
  assign out_b = {pc_write_b, pc_sel_b, br_sel_b, pc_rst_b, ir_load_b, rf_we_b,
                  wb_sel_b, alu_op_b, stat_en_b, dm_we_b, mm_sel_b, halted_b};

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];   // {state, control vector} per expected cycle

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] cur_out(input bit sc);
    return sc ? out_b : out_a;
  endfunction

  function automatic logic [2:0] cur_state(input bit sc);
    return sc ? state_b : state_a;
  endfunction

  // ---------------- reference model ----------------
  // Expected cycle list for one instruction, starting at FETCH.
  task automatic build_expect(input bit sc, input int op, input logic [3:0] mm,
                              input logic [3:0] st);
    logic [12:0] v;
    bit taken;
    bit is_mem;
    v = '0; v[B_PCW] = 1'b1; v[B_IRL] = 1'b1;
    exp_q.push_back({ST_FETCH, v});

    v = '0;
    taken = 1'b0;
    if (op == OP_BRA || op == OP_BRR) taken = (mm == 4'd0) || ((st & mm) != 4'd0);
    if (op == OP_BNE || op == OP_BNR) taken = ((st & mm) == 4'd0);
    if (taken) begin
      v[B_PCW] = 1'b1; v[B_PCSEL] = 1'b1;
      v[B_BRSEL] = (op == OP_BRA || op == OP_BNE);
    end
    exp_q.push_back({ST_DECODE, v});
    if (op == OP_HLT) return;

    v = '0;
    if (op == OP_ALU) begin
      v[B_ALU0] = (mm == 4'd8);
      v[B_STEN] = 1'b1;
    end else if (op == OP_LOD || op == OP_STR) begin
      v[B_ALU1] = 1'b1; v[B_ALU0] = 1'b1;
    end
    exp_q.push_back({ST_EXECUTE, v});

    is_mem = (op == OP_LOD || op == OP_STR || op == OP_SWP);
    if (!sc || is_mem) begin
      v = '0;
      if (op == OP_STR) begin v[B_DMWE] = 1'b1; v[B_MMSEL] = 1'b1; end
      if (op == OP_LOD) v[B_MMSEL] = 1'b1;
      exp_q.push_back({ST_MEM, v});
    end

    v = '0;
    if (op == OP_ALU || op == OP_SWP) v[B_RFWE] = 1'b1;
    if (op == OP_LOD) begin v[B_RFWE] = 1'b1; v[B_WBSEL] = 1'b1; v[B_MMSEL] = 1'b1; end
    exp_q.push_back({ST_WRITEBACK, v});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit sc, input logic [3:0] op, input logic [3:0] mm,
                        input logic [3:0] st);
    if (sc) begin opcode_b = op; mm_b = mm; stat_b = st; end
    else    begin opcode_a = op; mm_a = mm; stat_a = st; end
  endtask

  task automatic check_in_reset(input string tag);
    check_eq({tag, "_out_a"}, 32'(out_a), 32'(13'd1 << B_PCRST));
    check_eq({tag, "_st_a"}, 32'(state_a), 32'(ST_START0));
    check_eq({tag, "_out_b"}, 32'(out_b), 32'(13'd1 << B_PCRST));
    check_eq({tag, "_st_b"}, 32'(state_b), 32'(ST_START0));
  endtask

  // Reset both instances and walk them to FETCH.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_in_reset("rst_hold");
    step();
    step();
    rst = 1'b0;
    #1;
    check_eq("start0_out", 32'(out_a), 32'd0);
    check_eq("start0_st", 32'(state_a), 32'(ST_START0));
    step();
    check_eq("start1_out", 32'(out_a), 32'(13'd1 << B_PCRST));
    check_eq("start1_st", 32'(state_a), 32'(ST_START1));
    step();
  endtask

  // Run one instruction from FETCH; abort_at >= 0 raises rst in that cycle.
  task automatic run_instr(input bit sc, input logic [3:0] op, input logic [3:0] mm,
                           input logic [3:0] st, input int abort_at);
    logic [15:0] rec;
    int idx;
    set_in(sc, op, mm, st);
    exp_q.delete();
    build_expect(sc, int'(op), mm, st);
    idx = 0;
    while (exp_q.size() > 0) begin
      rec = exp_q.pop_front();
      check_eq($sformatf("st%0d_op%0d_c%0d", sc, op, idx), 32'(cur_state(sc)), 32'(rec[15:13]));
      check_eq($sformatf("out%0d_op%0d_mm%0h_s%0h_c%0d", sc, op, mm, st, idx),
               32'(cur_out(sc)), 32'(rec[12:0]));
      if (idx == abort_at) begin
        rst = 1'b1;
        #1;
        check_in_reset($sformatf("rst_mid_c%0d", idx));
        return;
      end
      step();
      idx++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] r_op, r_mm, r_st;
    set_in(1'b0, 4'd0, 4'd0, 4'd0);
    set_in(1'b1, 4'd0, 4'd0, 4'd0);
    do_reset();

    // Directed cases on the normal-cycle instance.
    run_instr(1'b0, 4'd8, 4'd8, 4'd0, -1);   // ALU immediate
    run_instr(1'b0, 4'd8, 4'd3, 4'd5, -1);   // ALU register
    run_instr(1'b0, 4'd1, 4'd5, 4'd0, -1);   // LOD
    run_instr(1'b0, 4'd2, 4'd5, 4'd0, -1);   // STR
    run_instr(1'b0, 4'd3, 4'd0, 4'd0, -1);   // SWP
    run_instr(1'b0, 4'd5, 4'd1, 4'd1, -1);   // BRR taken, relative
    run_instr(1'b0, 4'd6, 4'd1, 4'd1, -1);   // BNE not taken
    run_instr(1'b0, 4'd4, 4'd0, 4'd0, -1);   // BRA mm=0 always taken
    run_instr(1'b0, 4'd7, 4'd0, 4'hF, -1);   // BNR mm=0 always taken
    run_instr(1'b0, 4'd11, 4'd8, 4'hF, -1);  // unused code acts as NOOP

    // Reset mid-EXECUTE and mid-WRITEBACK of an ALU op.
    run_instr(1'b0, 4'd8, 4'd8, 4'd0, 2);
    do_reset();
    run_instr(1'b0, 4'd8, 4'd2, 4'd0, 4);
    do_reset();

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      r_op = 4'($urandom_range(0, 14));
      r_mm = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      r_st = 4'($urandom_range(0, 15));
      run_instr(1'b0, r_op, r_mm, r_st, -1);
    end

    // HLT: sticky regardless of inputs.
    run_instr(1'b0, 4'd15, 4'd0, 4'd0, -1);
    for (int i = 0; i < 20; i++) begin
      check_eq($sformatf("halt_st_%0d", i), 32'(state_a), 32'(ST_HALT));
      check_eq($sformatf("halt_out_%0d", i), 32'(out_a), 32'(13'd1 << B_HALT));
      set_in(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)));
      step();
    end
    do_reset();

    // Short-cycle instance.
    do_reset();
    run_instr(1'b1, 4'd0, 4'd0, 4'd0, -1);   // NOOP: 4 cycles
    check_eq("sc_noop_next_fetch", 32'(state_b), 32'(ST_FETCH));
    run_instr(1'b1, 4'd1, 4'd2, 4'd0, -1);   // LOD: still 5 cycles
    for (int i = 0; i < 40; i++) begin
      r_op = 4'($urandom_range(0, 14));
      r_mm = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      r_st = 4'($urandom_range(0, 15));
      run_instr(1'b1, r_op, r_mm, r_st, -1);
    end
    check_eq("sc_end_fetch", 32'(state_b), 32'(ST_FETCH));

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
